// File: rtl/riscv24_pkg.sv
// Shared constants for the 24-bit RISC datapath: word/immediate widths and
// the saturation limits of the 18-bit immediate field.
package riscv24_pkg;

  localparam int WORD_W = 24;
  localparam int IMM_W  = 18;
  localparam int OVF_CNT_W = 8;

  localparam logic [IMM_W-1:0] SAT_POS = 18'h1FFFF;
  localparam logic [IMM_W-1:0] SAT_NEG = 18'h20000;

endpackage

// File: rtl/narrow_core.sv
// Combinational narrowing of a two's-complement word to OUT_W bits, with
// overflow detection and optional saturation toward the nearest limit.
module narrow_core
  import riscv24_pkg::*;
#(
  parameter int IN_W  = WORD_W,
  parameter int OUT_W = IMM_W
) (
  input  logic [IN_W-1:0]  in_data,
  input  logic             sat_en,
  output logic [OUT_W-1:0] out_data,
  output logic             ovf
);

  localparam logic [OUT_W-1:0] SAT_HI = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_LO = {1'b1, {(OUT_W-1){1'b0}}};

  // The word fits when every bit from the new sign position upward agrees.
  logic [IN_W-OUT_W:0] upper_s;
  logic                fits_s;

  assign upper_s = in_data[IN_W-1:OUT_W-1];
  assign fits_s  = (&upper_s) | ~(|upper_s);

  // Select truncated or saturated result.
  always_comb begin
    out_data = in_data[OUT_W-1:0];
    ovf      = 1'b0;
    if (fits_s) begin
      out_data = in_data[OUT_W-1:0];
      ovf      = 1'b0;
    end else if (sat_en) begin
      out_data = in_data[IN_W-1] ? SAT_LO : SAT_HI;
      ovf      = 1'b1;
    end else begin
      out_data = in_data[OUT_W-1:0];
      ovf      = 1'b1;
    end
  end

endmodule

// File: rtl/sign_narrow.sv
// Registered, valid/ready narrowing stage: narrow_core feeds a 2-entry FIFO
// of pre-narrowed entries, plus a saturating count of overflowing words.
module sign_narrow
  import riscv24_pkg::*;
#(
  parameter int IN_W  = WORD_W,
  parameter int OUT_W = IMM_W,
  parameter int CNT_W = OVF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] ovf_count
);

  logic [OUT_W-1:0] nar_data_s;
  logic             nar_ovf_s;
  logic             push_s;
  logic             pop_s;

  logic [1:0]       count_q, count_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [OUT_W-1:0] data_q [2];
  logic [OUT_W-1:0] data_d [2];
  logic             ovf_q  [2];
  logic             ovf_d  [2];
  logic [CNT_W-1:0] ovf_count_q, ovf_count_d;

  narrow_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .in_data  (in_data),
    .sat_en   (sat_en),
    .out_data (nar_data_s),
    .ovf      (nar_ovf_s)
  );

  // Handshake flags come only from registered state, so out_ready never
  // reaches in_ready combinationally.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = data_q[rd_ptr_q];
  assign out_ovf   = ovf_q[rd_ptr_q];
  assign ovf_count = ovf_count_q;
  assign push_s    = in_valid && in_ready;
  assign pop_s     = out_valid && out_ready;

  // Next-state for FIFO storage, pointers, occupancy and overflow counter.
  always_comb begin
    data_d      = data_q;
    ovf_d       = ovf_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    ovf_count_d = ovf_count_q;

    if (push_s) begin
      data_d[wr_ptr_q] = nar_data_s;
      ovf_d[wr_ptr_q]  = nar_ovf_s;
      wr_ptr_d         = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    // A clear coinciding with an overflowing push still records that push.
    if (ovf_clr) begin
      ovf_count_d = (push_s && nar_ovf_s) ? {{(CNT_W-1){1'b0}}, 1'b1} : {CNT_W{1'b0}};
    end else if (push_s && nar_ovf_s && (ovf_count_q != {CNT_W{1'b1}})) begin
      ovf_count_d = ovf_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      ovf_count_d = ovf_count_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      ovf_count_q <= {CNT_W{1'b0}};
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= {OUT_W{1'b0}};
        ovf_q[i]  <= 1'b0;
      end
    end else begin
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ovf_count_q <= ovf_count_d;
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= data_d[i];
        ovf_q[i]  <= ovf_d[i];
      end
    end
  end

endmodule

// File: tb/tb_sign_narrow.sv
// Self-checking bench for sign_narrow: directed vector table, back-pressure,
// counter saturation and reset sequences, plus randomized traffic vs a queue model.
module tb_sign_narrow;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_data;
  logic        sat_en;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] out_data;
  logic        out_ovf;
  logic        ovf_clr;
  logic [7:0]  ovf_count;

  int checks = 0;
  int errors = 0;

  logic [18:0] mq[$];   // {ovf, data} in arrival order
  int          mcnt = 0;

  typedef struct {
    logic [23:0] d;
    logic        s;
    logic [17:0] ed;
    logic        eo;
  } vec_t;
  vec_t tbl[8];

  sign_narrow dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .sat_en    (sat_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .ovf_clr   (ovf_clr),
    .ovf_count (ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference narrowing from the signed value range of an 18-bit field.
  function automatic logic [18:0] ref_narrow(input logic [23:0] d, input logic s);
    int v;
    v = $signed({{8{d[23]}}, d});
    if (v >= -131072 && v <= 131071) return {1'b0, d[17:0]};
    if (s) return (v > 0) ? {1'b1, 18'h1FFFF} : {1'b1, 18'h20000};
    return {1'b1, d[17:0]};
  endfunction

  task automatic cyc(input logic iv, input logic [23:0] d, input logic s,
                     input logic ordy, input logic clr);
    logic        acc;
    logic        pp;
    logic [18:0] r;
    in_valid  = iv;
    in_data   = d;
    sat_en    = s;
    out_ready = ordy;
    ovf_clr   = clr;
    #1;
    chk("in_ready", in_ready, (mq.size() < 2));
    acc = iv && (mq.size() < 2);
    pp  = ordy && (mq.size() > 0);
    r   = ref_narrow(d, s);
    @(posedge clk);
    if (pp) void'(mq.pop_front());
    if (acc) mq.push_back(r);
    if (clr) mcnt = (acc && r[18]) ? 1 : 0;
    else if (acc && r[18] && mcnt < 255) mcnt++;
    #1;
    chk("out_valid", out_valid, (mq.size() > 0));
    if (mq.size() > 0) begin
      chk("out_data", out_data, mq[0][17:0]);
      chk("out_ovf", out_ovf, mq[0][18]);
    end
    chk("ovf_count", ovf_count, mcnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] w[3];
    logic [31:0] r;

    tbl[0] = '{24'h01FFFF, 1'b0, 18'h1FFFF, 1'b0};
    tbl[1] = '{24'hFE0000, 1'b0, 18'h20000, 1'b0};
    tbl[2] = '{24'h020000, 1'b0, 18'h20000, 1'b1};
    tbl[3] = '{24'h020000, 1'b1, 18'h1FFFF, 1'b1};
    tbl[4] = '{24'h800000, 1'b1, 18'h20000, 1'b1};
    tbl[5] = '{24'h7FFFFF, 1'b0, 18'h3FFFF, 1'b1};
    tbl[6] = '{24'hFDFFFF, 1'b1, 18'h20000, 1'b1};
    tbl[7] = '{24'hFE0001, 1'b1, 18'h20001, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_data = 24'h0; sat_en = 1'b0;
    out_ready = 1'b0; ovf_clr = 1'b0;
    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 18'h0);
    chk("rst_out_ovf", out_ovf, 1'b0);
    chk("rst_ovf_count", ovf_count, 8'd0);
    rst_n = 1'b1;

    // Directed table; with out_ready high each push also pops the previous word.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, tbl[i].d, tbl[i].s, 1'b1, 1'b0);
      chk("tbl_data", out_data, tbl[i].ed);
      chk("tbl_ovf", out_ovf, tbl[i].eo);
      if (i == 4) chk("tbl_ovf_count", ovf_count, 8'd3);
    end
    cyc(1'b0, 24'h0, 1'b0, 1'b1, 1'b0);

    // Back-pressure: third push refused, head stable, then in-order drain.
    w[0] = 24'h000123; w[1] = 24'hFFFF00; w[2] = 24'h0ABCDE;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, w[i], 1'b0, 1'b0, 1'b0);
      chk("bp_head", out_data, 18'h00123);
    end
    chk("bp_full", in_ready, 1'b0);
    cyc(1'b0, 24'h0, 1'b0, 1'b1, 1'b0);
    chk("bp_second", out_data, 18'h3FF00);
    cyc(1'b0, 24'h0, 1'b0, 1'b1, 1'b0);
    chk("bp_empty", out_valid, 1'b0);

    // Count=1 streaming: push and pop together for 10 cycles.
    cyc(1'b1, 24'h000011, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      r = $urandom;
      cyc(1'b1, {{6{r[17]}}, r[17:0]}, 1'b0, 1'b1, 1'b0);
      chk("stream_word", out_data, r[17:0]);
      chk("stream_ready", in_ready, 1'b1);
    end
    cyc(1'b0, 24'h0, 1'b0, 1'b1, 1'b0);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      r = $urandom;
      if ($urandom_range(0, 1) == 0) r[23:0] = {{6{r[17]}}, r[17:0]};
      cyc(1'($urandom_range(0, 3) != 0), r[23:0], 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
    end

    // Counter saturation and clear-with-overflow.
    cyc(1'b0, 24'h0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 24'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) cyc(1'b1, 24'h400000, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    chk("cnt_sat", ovf_count, 8'd255);
    cyc(1'b1, 24'h400000, 1'b0, 1'b1, 1'b1);
    chk("cnt_clr_ovf", ovf_count, 8'd1);

    // Asynchronous reset with two buffered words.
    cyc(1'b1, 24'h000777, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 24'h900000, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_full", in_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_ovf_count", ovf_count, 8'd0);
    chk("arst_out_data", out_data, 18'h0);
    mq.delete();
    mcnt = 0;
    #1 rst_n = 1'b1;
    cyc(1'b0, 24'h0, 1'b0, 1'b1, 1'b0);
    chk("post_rst_ready", in_ready, 1'b1);
    cyc(1'b1, 24'h000005, 1'b0, 1'b1, 1'b0);
    chk("post_rst_word", out_data, 18'h00005);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
